unencoded_tcam: RTL
===================

UNENCODED_TCAM -- requirements
Module: unencoded_tcam

Interface
- REQ-001: Parameter CMP_WIDTH, default 32, width of the compare key and the per-entry mask.
- REQ-002: Parameter LUT_DEPTH, default 32, number of entries.
- REQ-003: Parameter LUT_DEPTH_BITS, default log2(LUT_DEPTH), width of the write address.
- REQ-004: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-005: resetn  input  1  asynchronous, active-low reset.
- REQ-006: cam_cmp_din  input  CMP_WIDTH  lookup key, sampled every cycle.
- REQ-007: cam_cmp_data_mask  input  CMP_WIDTH  lookup don't-care bits; 1 = ignore that bit.
- REQ-008: cam_we  input  1  write request.
- REQ-009: cam_wr_addr  input  LUT_DEPTH_BITS  entry index to write.
- REQ-010: cam_din  input  CMP_WIDTH  entry compare data to write.
- REQ-011: cam_data_mask  input  CMP_WIDTH  entry don't-care bits to write; 1 = ignore that bit.
- REQ-012: cam_busy  output  1  high while initialising or committing a write.
- REQ-013: cam_match  output  1  at least one entry matched the key sampled on the previous edge.
- REQ-014: cam_match_addr  output  LUT_DEPTH  one-hot-or-more match vector; bit i = entry i matched.

Function
- REQ-015: Storage SHALL be LUT_DEPTH rows of {mask, data}, no reset on the rows, plus a LUT_DEPTH-bit valid vector with asynchronous reset.
- REQ-016: State machine SHALL have states INIT, IDLE, COMMIT; reset enters INIT.
- REQ-017: INIT: a LUT_DEPTH_BITS+1 counter from 0 SHALL write data=0, mask=0 to row[counter], one row per cycle; when counter == LUT_DEPTH, go to IDLE; INIT lasts exactly LUT_DEPTH+1 cycles after reset release.
- REQ-018: cam_busy SHALL be 1 in INIT and COMMIT, 0 in IDLE.
- REQ-019: IDLE with cam_we=1 SHALL latch cam_wr_addr, cam_din, cam_data_mask into a staging register and go to COMMIT.
- REQ-020: COMMIT SHALL write the staged data to the addressed row, set valid[addr], and return to IDLE after exactly one cycle.
- REQ-021: cam_we while cam_busy=1 SHALL be ignored, with no state or storage change and no queuing.
- REQ-022: cam_wr_addr >= LUT_DEPTH SHALL be accepted but write nothing, with valid unchanged; the busy cycle still occurs.
- REQ-023: Entry i SHALL match iff valid[i] and ((row_data[i] XOR key) AND NOT row_mask[i] AND NOT cam_cmp_data_mask) == 0.
- REQ-024: Lookup latency SHALL be 1 cycle: cam_match_addr and cam_match are registered from the key and mask sampled on the same edge. Lookups run every cycle, with no request strobe.
- REQ-025: cam_match SHALL equal the OR of the registered match vector, registered in the same flop stage, never derived from a stale vector.
- REQ-026: A lookup sampled on the COMMIT edge SHALL see pre-write contents; a lookup sampled on the following edge SHALL see the new entry.
- REQ-027: Overwriting an entry SHALL replace both data and mask; valid stays 1.
- REQ-028: Multiple simultaneous matches SHALL all be reported; no priority encoding in this block.
- REQ-029: In INIT, cam_match and cam_match_addr SHALL be forced to 0.

Reset
- REQ-030: On resetn=0, without waiting for a clock edge: state=INIT, counter=0, valid=0, staging=0, cam_busy=1, cam_match=0, cam_match_addr=0.
- REQ-031: resetn asserted mid-COMMIT SHALL abandon the write; after re-init the entry SHALL be invalid.
- REQ-032: Reset release SHALL be treated as synchronous to clk by the integrator; no internal synchroniser.

Verification
- REQ-033: Release reset, hold cam_we=0 -> cam_busy high exactly LUT_DEPTH+1 cycles, then 0; key 0 with mask 0 -> cam_match=0 (no valid entries).
- REQ-034: Write addr 5, data 0x0A000001, mask 0 -> busy 1 cycle; key 0x0A000001 one cycle later -> cam_match=1, cam_match_addr=0x00000020; key 0x0A000002 -> cam_match=0.
- REQ-035: Write addr 3 data 0x0A000000 mask 0x000000FF, and addr 7 data 0x0A000005 mask 0 -> key 0x0A000005 gives cam_match_addr=0x00000088; key 0x0A0000FE gives 0x00000008.
- REQ-036: Lookup key 0x01020304 sampled on the COMMIT edge of a write of that value to addr 0 -> cam_match=0; same key one edge later -> cam_match_addr bit 0 set.
- REQ-037: cam_we held high for 4 consecutive cycles with different addresses -> only cycles 1 and 3 accepted; the entries for cycles 2 and 4 stay invalid.
- REQ-038: resetn pulsed low during COMMIT of addr 2 -> outputs clear immediately; after re-init, a lookup of the written key gives cam_match=0.

Source files
------------

// File: rtl/unencoded_tcam.sv
// ---------------------------------------------------------------------------
// unencoded_tcam
//
// Ternary CAM that reports every matching entry as a bit vector. There is no
// priority encoding. Each entry holds {mask, data} and a valid bit. A mask
// bit of 1 means that bit of the entry is ignored. After reset the block
// zeroes every row, one row per cycle, and then accepts writes. A write takes
// one staging cycle followed by one commit cycle. Lookups run every cycle.
// The lookup result is registered, so it appears one cycle after the key.
//
// Ports
//   clk               : sole clock, all state updates on the rising edge
//   resetn            : asynchronous active-low reset
//   cam_cmp_din       : lookup key, sampled every cycle
//   cam_cmp_data_mask : lookup don't-care bits (1 = ignore)
//   cam_we            : write request, ignored while cam_busy is high
//   cam_wr_addr       : entry index to write
//   cam_din           : entry data to write
//   cam_data_mask     : entry don't-care bits to write (1 = ignore)
//   cam_busy          : high while initialising or committing a write
//   cam_match         : at least one entry matched the previous key
//   cam_match_addr    : per-entry match vector for the previous key
// ---------------------------------------------------------------------------
module unencoded_tcam #(
    parameter int CMP_WIDTH      = 32,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CMP_WIDTH-1:0]      cam_cmp_din,
    input  logic [CMP_WIDTH-1:0]      cam_cmp_data_mask,
    input  logic                      cam_we,
    input  logic [LUT_DEPTH_BITS-1:0] cam_wr_addr,
    input  logic [CMP_WIDTH-1:0]      cam_din,
    input  logic [CMP_WIDTH-1:0]      cam_data_mask,
    output logic                      cam_busy,
    output logic                      cam_match,
    output logic [LUT_DEPTH-1:0]      cam_match_addr
);

    localparam int               CNT_W    = LUT_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LUT_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          init_cnt_q, init_cnt_d;
    logic [LUT_DEPTH-1:0]      valid_q, valid_d;
    logic [LUT_DEPTH_BITS-1:0] stg_addr_q, stg_addr_d;
    logic [CMP_WIDTH-1:0]      stg_data_q, stg_data_d;
    logic [CMP_WIDTH-1:0]      stg_mask_q, stg_mask_d;
    logic [LUT_DEPTH-1:0]      match_addr_q, match_addr_d;
    logic                      match_q, match_d;

    // Entry storage. It has no reset. The INIT sweep clears it instead.
    logic [CMP_WIDTH-1:0]      row_data_q [LUT_DEPTH];
    logic [CMP_WIDTH-1:0]      row_mask_q [LUT_DEPTH];

    logic                      row_wr;
    logic [LUT_DEPTH_BITS-1:0] row_idx;
    logic [CMP_WIDTH-1:0]      row_wdata;
    logic [CMP_WIDTH-1:0]      row_wmask;
    logic [LUT_DEPTH-1:0]      row_we;
    logic [LUT_DEPTH-1:0]      hit;

    // Next-state logic, row write port and valid update.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        valid_d    = valid_q;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        stg_mask_d = stg_mask_q;
        row_wr     = 1'b0;
        row_idx    = '0;
        row_wdata  = '0;
        row_wmask  = '0;
        row_we     = '0;

        case (state_q)
            ST_INIT: begin
                // Zeroes rows 0..LUT_DEPTH-1. The terminal count adds one
                // more cycle, which is spent leaving INIT.
                row_idx = init_cnt_q[LUT_DEPTH_BITS-1:0];
                if (init_cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    row_wr     = 1'b1;
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (cam_we) begin
                    stg_addr_d = cam_wr_addr;
                    stg_data_d = cam_din;
                    stg_mask_d = cam_data_mask;
                    state_d    = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                row_wr    = 1'b1;
                row_idx   = stg_addr_q;
                row_wdata = stg_data_q;
                row_wmask = stg_mask_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // The decode covers only real rows. An out-of-range staged address
        // selects nothing, so neither storage nor valid changes for it.
        for (int i = 0; i < LUT_DEPTH; i++) begin
            row_we[i] = row_wr && (row_idx == LUT_DEPTH_BITS'(i));
        end

        if (state_q == ST_COMMIT) begin
            valid_d = valid_q | row_we;
        end
    end

    // Ternary compare. An entry hits when every bit that is cared about by
    // both the entry and the lookup is equal.
    always_comb begin
        hit = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            hit[i] = valid_q[i] &&
                     (((row_data_q[i] ^ cam_cmp_din) & ~row_mask_q[i] &
                       ~cam_cmp_data_mask) == '0);
        end
        match_addr_d = (state_q == ST_INIT) ? '0 : hit;
        match_d      = |match_addr_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            valid_q      <= '0;
            stg_addr_q   <= '0;
            stg_data_q   <= '0;
            stg_mask_q   <= '0;
            match_addr_q <= '0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            valid_q      <= valid_d;
            stg_addr_q   <= stg_addr_d;
            stg_data_q   <= stg_data_d;
            stg_mask_q   <= stg_mask_d;
            match_addr_q <= match_addr_d;
            match_q      <= match_d;
        end
    end

    // A lookup taken on the commit edge reads the rows before this update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (row_we[i]) begin
                row_data_q[i] <= row_wdata;
                row_mask_q[i] <= row_wmask;
            end
        end
    end

    assign cam_busy       = (state_q != ST_IDLE);
    assign cam_match      = match_q;
    assign cam_match_addr = match_addr_q;

endmodule
